// File: rtl/e203_exu_oitf_ooc.sv
// Outstanding instruction track FIFO: in-order allocate/retire, out-of-order completion by ITAG,
// with valid/ready retire port, global flush, occupancy count and illegal-completion pulse.
module e203_exu_oitf_ooc #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned ITAG_W  = 2,
    parameter int unsigned RFIDX_W = 5,
    parameter int unsigned PC_W    = 32,
    parameter int unsigned CNT_W   = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               dis_ena,
    output logic               dis_ready,
    output logic [ITAG_W-1:0]  dis_ptr,
    input  logic               disp_i_rs1en,
    input  logic               disp_i_rs2en,
    input  logic               disp_i_rs3en,
    input  logic               disp_i_rdwen,
    input  logic [RFIDX_W-1:0] disp_i_rs1idx,
    input  logic [RFIDX_W-1:0] disp_i_rs2idx,
    input  logic [RFIDX_W-1:0] disp_i_rs3idx,
    input  logic [RFIDX_W-1:0] disp_i_rdidx,
    input  logic [PC_W-1:0]    disp_i_pc,
    input  logic               cmt_ena,
    input  logic [ITAG_W-1:0]  cmt_itag,
    output logic               ret_vld,
    input  logic               ret_rdy,
    output logic [ITAG_W-1:0]  ret_ptr,
    output logic [RFIDX_W-1:0] ret_rdidx,
    output logic               ret_rdwen,
    output logic [PC_W-1:0]    ret_pc,
    input  logic               flush_ena,
    output logic               oitfrd_match_disprs1,
    output logic               oitfrd_match_disprs2,
    output logic               oitfrd_match_disprs3,
    output logic               oitfrd_match_disprd,
    output logic               oitf_empty,
    output logic               oitf_full,
    output logic [CNT_W-1:0]   oitf_cnt,
    output logic               cmt_err
);

    logic [DEPTH-1:0]   vld_q, vld_d, done_q, done_d;
    logic [ITAG_W-1:0]  alc_ptr_q, alc_ptr_d, ret_ptr_q, ret_ptr_d;
    logic               alc_flg_q, alc_flg_d, ret_flg_q, ret_flg_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               cmt_err_q, cmt_err_d;

    logic [RFIDX_W-1:0] rdidx_q [DEPTH];
    logic               rdwen_q [DEPTH];
    logic [PC_W-1:0]    pc_q    [DEPTH];

    logic [DEPTH-1:0]   alc_oh, ret_oh, cmt_oh;
    logic               cmt_ok, dis_fire, ret_fire;

    // Advance a wrap-flagged pointer; returns {flag, ptr}.
    function automatic logic [ITAG_W:0] ptr_adv(input logic [ITAG_W-1:0] p, input logic f);
        if (p == ITAG_W'(DEPTH - 1)) begin
            return {~f, ITAG_W'(0)};
        end
        return {f, p + ITAG_W'(1)};
    endfunction

    always_comb begin
        alc_oh = '0;
        ret_oh = '0;
        cmt_oh = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            alc_oh[i] = (alc_ptr_q == ITAG_W'(i));
            ret_oh[i] = (ret_ptr_q == ITAG_W'(i));
            cmt_oh[i] = (cmt_itag  == ITAG_W'(i));
        end
    end

    assign oitf_empty = (alc_ptr_q == ret_ptr_q) & (alc_flg_q == ret_flg_q);
    assign oitf_full  = (alc_ptr_q == ret_ptr_q) & (alc_flg_q != ret_flg_q);
    assign dis_ready  = ~oitf_full;
    assign dis_ptr    = alc_ptr_q;
    assign ret_ptr    = ret_ptr_q;
    assign ret_vld    = |(ret_oh & vld_q & done_q);
    assign oitf_cnt   = cnt_q;
    assign cmt_err    = cmt_err_q;

    // An ITAG outside the table selects no entry and so is never legal.
    assign cmt_ok   = cmt_ena & (|(cmt_oh & vld_q & ~done_q));
    assign dis_fire = dis_ena & ~oitf_full & ~flush_ena;
    assign ret_fire = ret_vld & ret_rdy & ~flush_ena;

    always_comb begin
        ret_rdidx = '0;
        ret_rdwen = 1'b0;
        ret_pc    = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (ret_oh[i]) begin
                ret_rdidx = rdidx_q[i];
                ret_rdwen = rdwen_q[i];
                ret_pc    = pc_q[i];
            end
        end
    end

    // Hazard match against registered entries only; done-but-unretired entries still count.
    always_comb begin
        oitfrd_match_disprs1 = 1'b0;
        oitfrd_match_disprs2 = 1'b0;
        oitfrd_match_disprs3 = 1'b0;
        oitfrd_match_disprd  = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (vld_q[i] & rdwen_q[i]) begin
                oitfrd_match_disprs1 |= disp_i_rs1en & (rdidx_q[i] == disp_i_rs1idx);
                oitfrd_match_disprs2 |= disp_i_rs2en & (rdidx_q[i] == disp_i_rs2idx);
                oitfrd_match_disprs3 |= disp_i_rs3en & (rdidx_q[i] == disp_i_rs3idx);
                oitfrd_match_disprd  |= disp_i_rdwen & (rdidx_q[i] == disp_i_rdidx);
            end
        end
    end

    always_comb begin
        vld_d     = vld_q;
        done_d    = done_q;
        alc_ptr_d = alc_ptr_q;
        alc_flg_d = alc_flg_q;
        ret_ptr_d = ret_ptr_q;
        ret_flg_d = ret_flg_q;
        cnt_d     = cnt_q;
        cmt_err_d = 1'b0;
        if (flush_ena) begin
            vld_d     = '0;
            done_d    = '0;
            alc_ptr_d = '0;
            alc_flg_d = 1'b0;
            ret_ptr_d = '0;
            ret_flg_d = 1'b0;
            cnt_d     = '0;
        end else begin
            cmt_err_d = cmt_ena & ~cmt_ok;
            if (cmt_ok) begin
                done_d = done_d | cmt_oh;
            end
            if (ret_fire) begin
                vld_d                  = vld_d & ~ret_oh;
                done_d                 = done_d & ~ret_oh;
                {ret_flg_d, ret_ptr_d} = ptr_adv(ret_ptr_q, ret_flg_q);
            end
            if (dis_fire) begin
                vld_d                  = vld_d | alc_oh;
                done_d                 = done_d & ~alc_oh;
                {alc_flg_d, alc_ptr_d} = ptr_adv(alc_ptr_q, alc_flg_q);
            end
            case ({dis_fire, ret_fire})
                2'b10:   cnt_d = cnt_q + CNT_W'(1);
                2'b01:   cnt_d = cnt_q - CNT_W'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q     <= '0;
            done_q    <= '0;
            alc_ptr_q <= '0;
            alc_flg_q <= 1'b0;
            ret_ptr_q <= '0;
            ret_flg_q <= 1'b0;
            cnt_q     <= '0;
            cmt_err_q <= 1'b0;
        end else begin
            vld_q     <= vld_d;
            done_q    <= done_d;
            alc_ptr_q <= alc_ptr_d;
            alc_flg_q <= alc_flg_d;
            ret_ptr_q <= ret_ptr_d;
            ret_flg_q <= ret_flg_d;
            cnt_q     <= cnt_d;
            cmt_err_q <= cmt_err_d;
        end
    end

    // Payload is written on allocation only and is never cleared.
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (dis_fire & alc_oh[i]) begin
                rdidx_q[i] <= disp_i_rdidx;
                rdwen_q[i] <= disp_i_rdwen;
                pc_q[i]    <= disp_i_pc;
            end
        end
    end

    cnt_matches_vld: assert property (@(posedge clk) disable iff (rst)
        $countones(vld_q) == 32'(cnt_q));

endmodule

// File: tb/tb_e203_exu_oitf_ooc.sv
// Randomized + directed bench for e203_exu_oitf_ooc, checked against an in-order queue model.
module tb_e203_exu_oitf_ooc;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned ITAG_W  = 2;
    localparam int unsigned RFIDX_W = 5;
    localparam int unsigned PC_W    = 32;
    localparam int unsigned CNT_W   = 3;

    logic               clk = 1'b0;
    logic               rst;
    logic               dis_ena, dis_ready;
    logic [ITAG_W-1:0]  dis_ptr;
    logic               disp_i_rs1en, disp_i_rs2en, disp_i_rs3en, disp_i_rdwen;
    logic [RFIDX_W-1:0] disp_i_rs1idx, disp_i_rs2idx, disp_i_rs3idx, disp_i_rdidx;
    logic [PC_W-1:0]    disp_i_pc;
    logic               cmt_ena;
    logic [ITAG_W-1:0]  cmt_itag;
    logic               ret_vld, ret_rdy;
    logic [ITAG_W-1:0]  ret_ptr;
    logic [RFIDX_W-1:0] ret_rdidx;
    logic               ret_rdwen;
    logic [PC_W-1:0]    ret_pc;
    logic               flush_ena;
    logic               m_rs1, m_rs2, m_rs3, m_rd;
    logic               oitf_empty, oitf_full, cmt_err;
    logic [CNT_W-1:0]   oitf_cnt;

    e203_exu_oitf_ooc #(.DEPTH(DEPTH), .ITAG_W(ITAG_W), .RFIDX_W(RFIDX_W), .PC_W(PC_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .dis_ena(dis_ena), .dis_ready(dis_ready), .dis_ptr(dis_ptr),
        .disp_i_rs1en(disp_i_rs1en), .disp_i_rs2en(disp_i_rs2en), .disp_i_rs3en(disp_i_rs3en),
        .disp_i_rdwen(disp_i_rdwen),
        .disp_i_rs1idx(disp_i_rs1idx), .disp_i_rs2idx(disp_i_rs2idx), .disp_i_rs3idx(disp_i_rs3idx),
        .disp_i_rdidx(disp_i_rdidx), .disp_i_pc(disp_i_pc),
        .cmt_ena(cmt_ena), .cmt_itag(cmt_itag),
        .ret_vld(ret_vld), .ret_rdy(ret_rdy), .ret_ptr(ret_ptr),
        .ret_rdidx(ret_rdidx), .ret_rdwen(ret_rdwen), .ret_pc(ret_pc),
        .flush_ena(flush_ena),
        .oitfrd_match_disprs1(m_rs1), .oitfrd_match_disprs2(m_rs2),
        .oitfrd_match_disprs3(m_rs3), .oitfrd_match_disprd(m_rd),
        .oitf_empty(oitf_empty), .oitf_full(oitf_full), .oitf_cnt(oitf_cnt), .cmt_err(cmt_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int itag;
        int rdidx;
        bit rdwen;
        longint pc;
        bit done;
    } ent_t;

    ent_t q[$];
    int   alc_n;
    int   ret_n;
    bit   err_exp;
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit exp_match(input bit en, input int idx);
        if (!en) return 1'b0;
        foreach (q[k]) if (q[k].rdwen && q[k].rdidx == idx) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit head_ready();
        return q.size() > 0 && q[0].done;
    endfunction

    task automatic check_outputs();
        bit rv;
        rv = head_ready();
        check("dis_ready",  64'(dis_ready),  64'(q.size() < DEPTH));
        check("dis_ptr",    64'(dis_ptr),    64'(alc_n % DEPTH));
        check("oitf_full",  64'(oitf_full),  64'(q.size() == DEPTH));
        check("oitf_empty", 64'(oitf_empty), 64'(q.size() == 0));
        check("oitf_cnt",   64'(oitf_cnt),   64'(q.size()));
        check("ret_vld",    64'(ret_vld),    64'(rv));
        check("ret_ptr",    64'(ret_ptr),    64'(ret_n % DEPTH));
        check("cmt_err",    64'(cmt_err),    64'(err_exp));
        check("match_rs1",  64'(m_rs1), 64'(exp_match(disp_i_rs1en, int'(disp_i_rs1idx))));
        check("match_rs2",  64'(m_rs2), 64'(exp_match(disp_i_rs2en, int'(disp_i_rs2idx))));
        check("match_rs3",  64'(m_rs3), 64'(exp_match(disp_i_rs3en, int'(disp_i_rs3idx))));
        check("match_rd",   64'(m_rd),  64'(exp_match(disp_i_rdwen, int'(disp_i_rdidx))));
        if (rv) begin
            check("ret_rdidx", 64'(ret_rdidx), 64'(q[0].rdidx));
            check("ret_rdwen", 64'(ret_rdwen), 64'(q[0].rdwen));
            check("ret_pc",    64'(ret_pc),    64'(q[0].pc));
        end
    endtask

    // Apply this cycle's inputs to the model: complete, then retire, then allocate.
    task automatic model_update();
        bit rv, ok, was_full;
        ent_t e;
        if (flush_ena) begin
            q.delete();
            alc_n = 0;
            ret_n = 0;
            err_exp = 1'b0;
            return;
        end
        rv = head_ready();
        was_full = (q.size() == DEPTH);
        ok = 1'b0;
        if (cmt_ena) begin
            foreach (q[k]) if (q[k].itag == int'(cmt_itag) && !q[k].done) begin
                q[k].done = 1'b1;
                ok = 1'b1;
            end
        end
        err_exp = cmt_ena && !ok;
        if (rv && ret_rdy) begin
            void'(q.pop_front());
            ret_n++;
        end
        if (dis_ena && !was_full) begin
            e.itag  = alc_n % DEPTH;
            e.rdidx = int'(disp_i_rdidx);
            e.rdwen = disp_i_rdwen;
            e.pc    = longint'(disp_i_pc);
            e.done  = 1'b0;
            q.push_back(e);
            alc_n++;
        end
    endtask

    task automatic step();
        #1 check_outputs();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic idle();
        dis_ena = 0; cmt_ena = 0; cmt_itag = '0; ret_rdy = 0; flush_ena = 0;
        disp_i_rs1en = 0; disp_i_rs2en = 0; disp_i_rs3en = 0; disp_i_rdwen = 0;
        disp_i_rs1idx = '0; disp_i_rs2idx = '0; disp_i_rs3idx = '0; disp_i_rdidx = '0;
        disp_i_pc = '0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        q.delete();
        alc_n = 0;
        ret_n = 0;
        err_exp = 1'b0;
        #1 check_outputs();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic set_dis(input bit en, input int rd, input bit rdw, input int pc);
        dis_ena = en;
        disp_i_rdidx = RFIDX_W'(rd);
        disp_i_rdwen = rdw;
        disp_i_pc = PC_W'(pc);
    endtask

    task automatic set_cmt(input bit en, input int tag);
        cmt_ena = en;
        cmt_itag = ITAG_W'(tag);
    endtask

    initial begin
        rst = 1'b0;
        idle();
        @(negedge clk);
        do_reset();

        // Out-of-order completion, in-order retirement.
        for (int i = 0; i < 3; i++) begin
            idle(); set_dis(1, i + 1, 1, 'h100 + 4 * i); step();
        end
        idle(); ret_rdy = 1; set_cmt(1, 2); step();
        idle(); ret_rdy = 1; set_cmt(1, 1); step();
        idle(); ret_rdy = 1; check("ooo_hold", 64'(ret_vld), 64'(0)); set_cmt(1, 0); step();
        for (int i = 0; i < 4; i++) begin
            idle(); ret_rdy = 1; step();
        end
        check("ooo_drained", 64'(q.size()), 64'(0));

        // Fill, blocked fifth dispatch, then retire/dispatch across the wrap.
        idle(); flush_ena = 1; step();
        for (int i = 0; i < 5; i++) begin
            idle(); set_dis(1, 8 + i, 1, 'h200 + 4 * i); step();
        end
        #1 check("full_lit", 64'(oitf_full), 64'(1));
        idle(); set_cmt(1, 0); set_dis(1, 20, 1, 'h300); step();
        idle(); ret_rdy = 1; set_dis(1, 21, 1, 'h304); step();
        idle(); set_dis(1, 22, 1, 'h308); step();
        #1 check("wrap_cnt", 64'(oitf_cnt), 64'(4));

        // Hazard match on rs2, disabled, then after retire.
        idle(); flush_ena = 1; step();
        idle(); set_dis(1, 5, 1, 'h400); step();
        idle(); disp_i_rs2en = 1; disp_i_rs2idx = 5; step();
        idle(); disp_i_rs2en = 0; disp_i_rs2idx = 5; step();
        idle(); set_cmt(1, 0); step();
        idle(); ret_rdy = 1; step();
        idle(); disp_i_rs2en = 1; disp_i_rs2idx = 5; step();

        // Illegal completions: empty entry, then an already-done entry.
        idle(); set_dis(1, 6, 1, 'h500); step();
        idle(); set_cmt(1, 3); step();
        idle(); set_cmt(1, 1); step();
        idle(); set_cmt(1, 1); step();
        idle(); step();

        // Flush with concurrent dispatch, completion and retire.
        idle(); set_dis(1, 7, 1, 'h600); step();
        idle(); set_cmt(1, 2); step();
        idle(); flush_ena = 1; ret_rdy = 1; set_cmt(1, 1); set_dis(1, 9, 1, 'h700); step();
        idle(); set_dis(1, 10, 1, 'h800); step();
        idle(); step();

        // Asynchronous reset with three live entries.
        for (int i = 0; i < 3; i++) begin
            idle(); set_dis(1, i, 1, 'h900 + 4 * i); step();
        end
        do_reset();

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            idle();
            dis_ena       = ($urandom_range(0, 1) == 1);
            disp_i_rdwen  = ($urandom_range(0, 3) != 0);
            disp_i_rdidx  = RFIDX_W'($urandom_range(0, 7));
            disp_i_pc     = PC_W'($urandom);
            disp_i_rs1en  = ($urandom_range(0, 1) == 1);
            disp_i_rs2en  = ($urandom_range(0, 1) == 1);
            disp_i_rs3en  = ($urandom_range(0, 1) == 1);
            disp_i_rs1idx = RFIDX_W'($urandom_range(0, 7));
            disp_i_rs2idx = RFIDX_W'($urandom_range(0, 7));
            disp_i_rs3idx = RFIDX_W'($urandom_range(0, 7));
            cmt_ena       = ($urandom_range(0, 2) != 0);
            if (q.size() > 0 && $urandom_range(0, 9) < 7)
                cmt_itag = ITAG_W'(q[$urandom_range(0, q.size() - 1)].itag);
            else
                cmt_itag = ITAG_W'($urandom_range(0, DEPTH - 1));
            ret_rdy   = ($urandom_range(0, 3) != 0);
            flush_ena = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 499) == 0) do_reset();
            else step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/e203_exu_oitf_ooc.md
Name: e203_exu_oitf_ooc

Overview:
Parametrised Outstanding Instructions Track FIFO that supports out-of-order completion with in-order retirement. It sits at the EXU dispatch point and allocates one entry per dispatched long-pipe instruction. Long-pipe units mark entries done by ITAG in any order, and the block presents the oldest done entry to the writeback arbiter through a valid/ready handshake. It adds the following beyond a basic OITF:
- per-entry done tracking
- retire handshake
- global flush
- occupancy count
- illegal-completion detection

Parameters:
DEPTH, 4, number of entries; any integer >= 2 (not restricted to powers of two)
ITAG_W, 2, entry index width; must satisfy 2**ITAG_W >= DEPTH
RFIDX_W, 5, register index width
PC_W, 32, PC width
CNT_W, 3, occupancy counter width; must satisfy 2**CNT_W > DEPTH

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
dis_ena  in  1  allocate entry this cycle; legal only when dis_ready=1
dis_ready  out  1  ~oitf_full
dis_ptr  out  ITAG_W  index of the entry that will be allocated
disp_i_rs1en/rs2en/rs3en  in  1 each  dispatching instruction reads rs1/rs2/rs3
disp_i_rdwen  in  1  dispatching instruction writes rd
disp_i_rs1idx/rs2idx/rs3idx/rdidx  in  RFIDX_W each  register indices of dispatching instruction
disp_i_pc  in  PC_W  PC of dispatching instruction
cmt_ena  in  1  a long-pipe unit completes an instruction
cmt_itag  in  ITAG_W  ITAG of the completing instruction
ret_vld  out  1  head entry valid and done
ret_rdy  in  1  writeback accepts head entry
ret_ptr  out  ITAG_W  head index
ret_rdidx  out  RFIDX_W  head rd index
ret_rdwen  out  1  head rd write enable
ret_pc  out  PC_W  head PC
flush_ena  in  1  discard all entries
oitfrd_match_disprs1/rs2/rs3/rd  out  1 each  hazard match against dispatching instruction
oitf_empty  out  1  no valid entries
oitf_full  out  1  all entries valid
oitf_cnt  out  CNT_W  number of valid entries
cmt_err  out  1  registered pulse on illegal completion

Behaviour:
- Reset (async, rst=1): all vld/done cleared; alc/ret pointers and wrap flags = 0; oitf_cnt=0; oitf_empty=1; oitf_full=0; dis_ready=1; ret_vld=0; all match outputs 0; cmt_err=0. Payload registers (rdidx, rdwen, pc) are not reset.
- Pointers: alc_ptr and ret_ptr each carry a wrap flag.
  - A pointer advances by 1; from DEPTH-1 it wraps to 0 and toggles its flag.
  - empty = (ptrs equal) & (flags equal); full = (ptrs equal) & (flags differ).
- Dispatch: on dis_ena & dis_ready, entry[alc_ptr] gets vld=1, done=0, and the payload is written. alc_ptr advances. dis_ena while full is ignored; no state changes.
- Completion: on cmt_ena, if entry[cmt_itag] is vld and not done, set done=1 (visible the next cycle).
  - If the entry is not vld, is already done, or cmt_itag >= DEPTH, the completion is ignored and cmt_err pulses for 1 cycle, one cycle later.
- Retire: ret_vld = vld[ret_ptr] & done[ret_ptr], combinational from registers. On ret_vld & ret_rdy, entry[ret_ptr] clears vld and done, and ret_ptr advances.
  - ret_rdidx/ret_rdwen/ret_pc always reflect entry[ret_ptr], whether or not ret_vld is high.
- Completion-to-retire latency: minimum 1 cycle (completion registered, then retire).
- Simultaneous events:
  - Dispatch and retire in the same cycle are both allowed; oitf_cnt is unchanged.
  - Dispatch while full is blocked even if a retire occurs the same cycle (no same-cycle slot reuse).
  - Completion targeting the entry being allocated the same cycle is illegal and ignored (entry not yet vld), and cmt_err pulses.
  - Completion and retire of different entries in the same cycle are both honoured.
- oitf_cnt: +1 on dispatch, -1 on retire, unchanged when both occur; it is a register, not derived from the pointers.
- Flush (flush_ena=1): highest priority; dispatch, completion and retire in that cycle are discarded.
  - Next cycle: all vld/done=0, pointers and flags=0, cnt=0, empty=1.
  - cmt_err is not raised for completions arriving during the flush cycle.
- Hazard match:
  - match_rsN = OR over i of (vld[i] & rdwen[i] & disp_i_rsNen & rdidx[i]==disp_i_rsNidx).
  - match_rd uses disp_i_rdwen and disp_i_rdidx in the same way.
  - Done-but-unretired entries still match.
  - Matching is purely combinational against registered state; the instruction being dispatched this cycle never matches itself.
- Invariant (assertion): oitf_cnt equals popcount(vld) at all times.

Test Plan:
- Reset then idle: rst pulse mid-run with 3 valid entries -> immediately empty=1, cnt=0, ret_vld=0, dis_ptr=0, all matches 0.
- Out-of-order completion, DEPTH=4: dispatch ITAGs 0,1,2; complete 2, then 1, then 0 with ret_rdy=1 -> ret_vld stays 0 until the cycle after completing 0; retires 0,1,2 on consecutive cycles with ret_pc matching dispatch order.
- Full and wrap: 4 dispatches -> full=1, dis_ready=0; 5th dis_ena ignored. Complete and retire ITAG 0, then dispatch -> dis_ptr=0, alc flag toggled, cnt=4.
- Hazard: entry holds rdwen=1, rdidx=5; dispatch with rs2en=1, rs2idx=5 -> match_disprs2=1. With rs2en=0 -> 0. After that entry retires -> 0.
- Illegal completion: cmt_ena with ITAG of an empty entry, and again with an already-done ITAG -> cmt_err pulses 1 cycle later each time; no state change.
- Flush with concurrent traffic: flush_ena with dis_ena, cmt_ena and a retire handshake in the same cycle -> next cycle cnt=0, empty=1, pointers=0, cmt_err=0; the following dispatch lands at ITAG 0.
